seq_magnitude_cmp_ctrl: RTL

//  Multi-cycle controller that compares two WIDTH-bit unsigned operands with one 4-bit

---
 rtl/cmp_pkg.sv | 17 +
 rtl/nibble_gt_eq.sv | 15 +
 rtl/seq_magnitude_cmp_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the nibble-serial magnitude comparator.
// Optional feature macro: CMP_EARLY_EXIT_EN.
package cmp_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      DONE
   } state_t;

   function automatic int cnt_w(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nibble_gt_eq.sv
// Combinational 4-bit greater-than / equal slice shared by the controller.
// Optional feature macro: CMP_EARLY_EXIT_EN (no effect in this file).
module nibble_gt_eq
   import cmp_pkg::*;
(
   input  logic [NIB_W-1:0] x,
   input  logic [NIB_W-1:0] y,
   output logic             gt,
   output logic             eq
);

   assign gt = (x > y);
   assign eq = (x == y);

endmodule

// File: rtl/seq_magnitude_cmp_ctrl.sv
// Nibble-serial unsigned magnitude comparator controller, MSB nibble first.
// Optional feature macro: CMP_EARLY_EXIT_EN (stop at the first differing nibble).
module seq_magnitude_cmp_ctrl
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq
);

   localparam int NIBBLES = WIDTH / NIB_W;
   localparam int CW      = cnt_w(NIBBLES);

   if ((WIDTH < NIB_W) || ((WIDTH % NIB_W) != 0)) begin : g_bad_width
      $error("WIDTH must be a multiple of 4 and at least 4");
   end

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [CW-1:0]    cnt;
   logic             gt_acc;
   logic             eq_acc;
   logic             gt_q;
   logic             eq_q;
   logic             nib_gt;
   logic             nib_eq;
   logic             acc_gt_nx;
   logic             acc_eq_nx;
   logic             last;

   nibble_gt_eq u_slice (
      .x  (sh_a[WIDTH-1 -: NIB_W]),
      .y  (sh_b[WIDTH-1 -: NIB_W]),
      .gt (nib_gt),
      .eq (nib_eq)
   );

   // Once a difference has been seen the accumulated result is frozen.
   always_comb begin
      acc_eq_nx = eq_acc & nib_eq;
      acc_gt_nx = eq_acc ? nib_gt : gt_acc;
   end

`ifdef CMP_EARLY_EXIT_EN
   assign last = (cnt == '0) || (eq_acc && !nib_eq);
`else
   assign last = (cnt == '0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CMP;
         CMP:     if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Results are loaded on the CMP->DONE edge so they are valid with done.
   always_ff @(posedge clk) begin
      if (reset) begin
         sh_a   <= '0;
         sh_b   <= '0;
         cnt    <= '0;
         gt_acc <= 1'b0;
         eq_acc <= 1'b0;
         gt_q   <= 1'b0;
         eq_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sh_a   <= a;
                  sh_b   <= b;
                  cnt    <= CW'(NIBBLES - 1);
                  gt_acc <= 1'b0;
                  eq_acc <= 1'b1;
               end
            end
            CMP: begin
               sh_a   <= sh_a << NIB_W;
               sh_b   <= sh_b << NIB_W;
               cnt    <= cnt - 1'b1;
               gt_acc <= acc_gt_nx;
               eq_acc <= acc_eq_nx;
               if (last) begin
                  gt_q <= acc_gt_nx;
                  eq_q <= acc_eq_nx;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign gt   = gt_q;
   assign eq   = eq_q;

endmodule
